iddmm_operand_loader: RTL and testbench



---
 rtl/iddmm_operand_loader.sv | 143 ++++++++++++++
 tb/tb_iddmm_operand_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iddmm_operand_loader.sv
// IDDMM operand loader: streams x, y and m words into the operand RAMs, then pulses finish_reg_flag.
// Optional s_last framing check is enabled by defining IDDMM_LOADER_LAST_CHECK_EN.
module iddmm_operand_loader #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [K-1:0]      s_data,
    input  logic              s_last,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_data,
    output logic              busy,
    output logic              finish_reg_flag,
    output logic              load_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [1:0]         r_sel_cnt;
    logic               r_wr_en;
    logic [1:0]         r_wr_sel;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [K-1:0]       r_wr_data;
    logic               r_finish;
    logic               r_load_err;

    logic               w_accept;
    logic               w_start;
    logic               w_word_last;
    logic               w_final_pos;
    logic               w_frame_err;

    assign w_start     = (r_state == IDLE) && load_start;
    assign w_accept    = (r_state == LOAD) && s_valid;
    assign w_word_last = (r_word_cnt == LAST_WORD);
    assign w_final_pos = (r_sel_cnt == 2'd2) && w_word_last;

`ifdef IDDMM_LOADER_LAST_CHECK_EN
    // s_last must be high exactly on the beat that completes the m operand.
    assign w_frame_err = w_accept && (s_last != w_final_pos);
`else
    logic w_unused_last;
    assign w_unused_last = s_last;
    assign w_frame_err   = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (load_start) w_next_state = LOAD;
            LOAD: begin
                if (w_frame_err)
                    w_next_state = IDLE;
                else if (w_accept && w_final_pos)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Word counter runs 0..N-1 inside each operand; the select counter steps x -> y -> m.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_sel_cnt  <= 2'd0;
        end else if (w_start) begin
            r_word_cnt <= '0;
            r_sel_cnt  <= 2'd0;
        end else if (w_accept) begin
            if (w_word_last) begin
                r_word_cnt <= '0;
                r_sel_cnt  <= r_sel_cnt + 2'd1;
            end else begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_sel  <= 2'd0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_sel  <= r_sel_cnt;
                r_wr_addr <= r_word_cnt[ADDR_W-1:0];
                r_wr_data <= s_data;
            end
        end
    end

    // The flag is registered off DONE so it lands one cycle after the final RAM write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_finish   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_finish <= (r_state == DONE);
            if (w_start)
                r_load_err <= 1'b0;
            else if (w_frame_err)
                r_load_err <= 1'b1;
        end
    end

    assign s_ready         = (r_state == LOAD);
    assign busy            = (r_state != IDLE) || r_finish;
    assign wr_en           = r_wr_en;
    assign wr_sel          = r_wr_sel;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign finish_reg_flag = r_finish;
    assign load_err        = r_load_err;

endmodule

// File: tb/tb_iddmm_operand_loader.sv
// Directed self-checking bench for iddmm_operand_loader with K=128, N=4.
// Write and flag activity is captured by a negedge monitor and compared inside each test task.
module tb_iddmm_operand_loader;

    localparam int K      = 128;
    localparam int N      = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              loadStart;
    logic              sValid;
    logic              sReady;
    logic [K-1:0]      sData;
    logic              sLast;
    logic              wrEn;
    logic [1:0]        wrSel;
    logic [ADDR_W-1:0] wrAddr;
    logic [K-1:0]      wrData;
    logic              busy;
    logic              finishFlag;
    logic              loadErr;

    typedef struct {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [K-1:0]      data;
    } wr_t;

    wr_t wrQ[$];
    int  flagQ[$];
    int  cyc;
    int  lastAccept;
    int  nChecks;
    int  nFails;

    int expSel[12]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int expAddr[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};

    iddmm_operand_loader #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_start      (loadStart),
        .s_valid         (sValid),
        .s_ready         (sReady),
        .s_data          (sData),
        .s_last          (sLast),
        .wr_en           (wrEn),
        .wr_sel          (wrSel),
        .wr_addr         (wrAddr),
        .wr_data         (wrData),
        .busy            (busy),
        .finish_reg_flag (finishFlag),
        .load_err        (loadErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every RAM write, every flag cycle and the cycle of the latest accepted beat.
    always @(negedge clk) begin
        if (wrEn) wrQ.push_back('{sel: wrSel, addr: wrAddr, data: wrData});
        if (finishFlag) flagQ.push_back(cyc);
        if (sValid && sReady) lastAccept = cyc;
    end

    task automatic clear_logs();
        wrQ.delete();
        flagQ.delete();
        lastAccept = -100;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load();
        @(posedge clk);
        #1 loadStart = 1'b1;
        @(posedge clk);
        #1 loadStart = 1'b0;
    endtask

    // Drives beats 0..nBeats-1 with data = beat index; returns #1 after the last accepting edge.
    task automatic drive_beats(input int nBeats, input bit gaps, input int restartBeat, input int badLastBeat);
        for (int b = 0; b < nBeats; b++) begin
            sValid = 1'b1;
            sData  = K'(b);
            sLast  = (b == 3 * N - 1) ^ (b == badLastBeat);
            if (b == restartBeat) loadStart = 1'b1;
            @(posedge clk);
            #1;
            loadStart = 1'b0;
            if (gaps && b != nBeats - 1) begin
                sValid = 1'b0;
                sData  = {K{1'b1}};
                sLast  = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        sValid = 1'b0;
        sLast  = 1'b0;
        sData  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({sReady, wrEn, wrSel, wrAddr, wrData, busy, finishFlag, loadErr} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got ready=%b en=%b sel=%0d addr=%0d data=%0h busy=%b flag=%b err=%b, expected all 0",
                     sReady, wrEn, wrSel, wrAddr, wrData, busy, finishFlag, loadErr);
        end
        idle_cycles(2);
        rst_n = 1'b1;
        clear_logs();
        sValid = 1'b1;
        sData  = K'(77);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            nChecks++;
            if (sReady !== 1'b0 || wrEn !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL idle_no_accept: got ready=%b en=%b, expected 0 0", sReady, wrEn);
            end
        end
        sValid = 1'b0;
        sData  = '0;
        idle_cycles(1);
        nChecks++;
        if (wrQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL idle_writes: got %0d writes, expected 0", wrQ.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        start_load();
        nChecks++;
        if (sReady !== 1'b1 || busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL start_ready: got ready=%b busy=%b, expected 1 1", sReady, busy);
        end
        drive_beats(12, 1'b0, -1, -1);
        nChecks++;
        if (wrEn !== 1'b1 || sReady !== 1'b0 || busy !== 1'b1 || finishFlag !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL tail_t1: got en=%b ready=%b busy=%b flag=%b, expected 1 0 1 0", wrEn, sReady, busy, finishFlag);
        end
        idle_cycles(1);
        nChecks++;
        if (wrEn !== 1'b0 || finishFlag !== 1'b1 || busy !== 1'b1 || wrData !== K'(11)) begin
            nFails++;
            $display("[TB] FAIL tail_t2: got en=%b flag=%b busy=%b data=%0h, expected 0 1 1 b", wrEn, finishFlag, busy, wrData);
        end
        idle_cycles(1);
        nChecks++;
        if (finishFlag !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL tail_t3: got flag=%b busy=%b, expected 0 0", finishFlag, busy);
        end
        idle_cycles(2);
        nChecks++;
        if (wrQ.size() != 12) begin
            nFails++;
            $display("[TB] FAIL b2b_count: got %0d writes, expected 12", wrQ.size());
        end
        for (int i = 0; i < 12 && i < wrQ.size(); i++) begin
            nChecks++;
            if (wrQ[i].sel !== 2'(expSel[i]) || wrQ[i].addr !== 2'(expAddr[i]) || wrQ[i].data !== K'(i)) begin
                nFails++;
                $display("[TB] FAIL b2b_write%0d: got sel=%0d addr=%0d data=%0h, expected sel=%0d addr=%0d data=%0h",
                         i, wrQ[i].sel, wrQ[i].addr, wrQ[i].data, expSel[i], expAddr[i], i);
            end
        end
        nChecks++;
        if (flagQ.size() != 1 || flagQ[0] != lastAccept + 2) begin
            nFails++;
            $display("[TB] FAIL b2b_flag: got %0d pulses first at cycle %0d, expected 1 pulse at cycle %0d",
                     flagQ.size(), (flagQ.size() > 0) ? flagQ[0] : -1, lastAccept + 2);
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        start_load();
        drive_beats(12, 1'b1, -1, -1);
        idle_cycles(4);
        nChecks++;
        if (wrQ.size() != 12) begin
            nFails++;
            $display("[TB] FAIL gap_count: got %0d writes, expected 12", wrQ.size());
        end
        for (int i = 0; i < 12 && i < wrQ.size(); i++) begin
            nChecks++;
            if (wrQ[i].sel !== 2'(expSel[i]) || wrQ[i].addr !== 2'(expAddr[i]) || wrQ[i].data !== K'(i)) begin
                nFails++;
                $display("[TB] FAIL gap_write%0d: got sel=%0d addr=%0d data=%0h, expected sel=%0d addr=%0d data=%0h",
                         i, wrQ[i].sel, wrQ[i].addr, wrQ[i].data, expSel[i], expAddr[i], i);
            end
        end
        nChecks++;
        if (flagQ.size() != 1 || flagQ[0] != lastAccept + 2) begin
            nFails++;
            $display("[TB] FAIL gap_flag: got %0d pulses first at cycle %0d, expected 1 pulse at cycle %0d",
                     flagQ.size(), (flagQ.size() > 0) ? flagQ[0] : -1, lastAccept + 2);
        end
    endtask

    task automatic test_restart_ignored();
        clear_logs();
        start_load();
        drive_beats(12, 1'b0, 5, -1);
        idle_cycles(4);
        nChecks++;
        if (wrQ.size() != 12 || flagQ.size() != 1) begin
            nFails++;
            $display("[TB] FAIL restart_load: got %0d writes %0d flags, expected 12 writes 1 flag", wrQ.size(), flagQ.size());
        end
        for (int i = 0; i < 12 && i < wrQ.size(); i++) begin
            nChecks++;
            if (wrQ[i].sel !== 2'(expSel[i]) || wrQ[i].addr !== 2'(expAddr[i]) || wrQ[i].data !== K'(i)) begin
                nFails++;
                $display("[TB] FAIL restart_write%0d: got sel=%0d addr=%0d data=%0h, expected sel=%0d addr=%0d data=%0h",
                         i, wrQ[i].sel, wrQ[i].addr, wrQ[i].data, expSel[i], expAddr[i], i);
            end
        end
        clear_logs();
        start_load();
        drive_beats(1, 1'b0, -1, -1);
        nChecks++;
        if (wrEn !== 1'b1 || wrSel !== 2'd0 || wrAddr !== 2'd0 || wrData !== K'(0)) begin
            nFails++;
            $display("[TB] FAIL second_load_first: got en=%b sel=%0d addr=%0d data=%0h, expected 1 0 0 0", wrEn, wrSel, wrAddr, wrData);
        end
        drive_beats(0, 1'b0, -1, -1);
    endtask

    task automatic test_mid_reset();
        // The previous task left a load in progress after one beat; reset clears it.
        clear_logs();
        drive_beats(7, 1'b0, -1, -1);
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({sReady, wrEn, wrSel, wrAddr, wrData, busy, finishFlag, loadErr} !== '0) begin
            nFails++;
            $display("[TB] FAIL midreset_outputs: got ready=%b en=%b sel=%0d addr=%0d data=%0h busy=%b flag=%b err=%b, expected all 0",
                     sReady, wrEn, wrSel, wrAddr, wrData, busy, finishFlag, loadErr);
        end
        idle_cycles(1);
        rst_n = 1'b1;
        idle_cycles(4);
        nChecks++;
        if (wrQ.size() != 7 || flagQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL midreset_log: got %0d writes %0d flags, expected 7 writes 0 flags", wrQ.size(), flagQ.size());
        end
        clear_logs();
        start_load();
        drive_beats(12, 1'b0, -1, -1);
        idle_cycles(4);
        nChecks++;
        if (wrQ.size() != 12 || flagQ.size() != 1) begin
            nFails++;
            $display("[TB] FAIL postreset_load: got %0d writes %0d flags, expected 12 writes 1 flag", wrQ.size(), flagQ.size());
        end
        else if (wrQ[0].sel !== 2'd0 || wrQ[0].addr !== 2'd0 || wrQ[11].sel !== 2'd2 || wrQ[11].addr !== 2'd3 || wrQ[11].data !== K'(11)) begin
            nFails++;
            $display("[TB] FAIL postreset_order: got first (%0d,%0d) last (%0d,%0d,%0h), expected (0,0) (2,3,b)",
                     wrQ[0].sel, wrQ[0].addr, wrQ[11].sel, wrQ[11].addr, wrQ[11].data);
        end
    endtask

    task automatic test_last_check();
        clear_logs();
        start_load();
`ifdef IDDMM_LOADER_LAST_CHECK_EN
        drive_beats(6, 1'b0, -1, 5);
        nChecks++;
        if (wrEn !== 1'b1 || wrSel !== 2'd1 || wrAddr !== 2'd1 || wrData !== K'(5) || loadErr !== 1'b1 || sReady !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL frame_err: got en=%b sel=%0d addr=%0d data=%0h err=%b ready=%b, expected 1 1 1 5 1 0",
                     wrEn, wrSel, wrAddr, wrData, loadErr, sReady);
        end
        idle_cycles(4);
        nChecks++;
        if (wrQ.size() != 6 || flagQ.size() != 0 || loadErr !== 1'b1 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL frame_after: got %0d writes %0d flags err=%b busy=%b, expected 6 0 1 0",
                     wrQ.size(), flagQ.size(), loadErr, busy);
        end
        start_load();
        nChecks++;
        if (loadErr !== 1'b0 || sReady !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL err_clear: got err=%b ready=%b, expected 0 1", loadErr, sReady);
        end
        drive_beats(12, 1'b0, -1, -1);
        idle_cycles(4);
`else
        drive_beats(12, 1'b0, -1, 5);
        idle_cycles(4);
        nChecks++;
        if (wrQ.size() != 12 || flagQ.size() != 1 || loadErr !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL last_ignored: got %0d writes %0d flags err=%b, expected 12 1 0", wrQ.size(), flagQ.size(), loadErr);
        end
`endif
    endtask

    initial begin
        cyc        = 0;
        nChecks    = 0;
        nFails     = 0;
        lastAccept = -100;
        loadStart  = 1'b0;
        sValid     = 1'b0;
        sData      = '0;
        sLast      = 1'b0;
        rst_n      = 1'b1;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_restart_ignored();
        test_mid_reset();
        test_last_check();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
